// File: rtl/sysid_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sysid_pkg
//  Description : Shared types and constants for the system-ID boot checker.
//                Holds the sequencer state encoding, the sysid word
//                addresses and a small state-classification helper.
//  Ports       : none (package)
//  Revision    : 1.0  initial release
// ============================================================================
package sysid_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD_ID = 3'd1,
        S_WT_ID = 3'd2,
        S_RD_TS = 3'd3,
        S_WT_TS = 3'd4,
        S_CHECK = 3'd5
    } state_t;

    localparam logic ADDR_ID = 1'b0;
    localparam logic ADDR_TS = 1'b1;

    // True in the states that present a read request on the bus.
    function automatic logic is_rd_state(input state_t s);
        return (s == S_RD_ID) || (s == S_RD_TS);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sysid_boot_checker_if.sv
`default_nettype none
// ============================================================================
//  Module      : sysid_boot_checker_if
//  Description : Avalon-MM read-only bus between the boot checker (master)
//                and the sysid control_slave.
//  Signals     : address        0 = ID word, 1 = timestamp word
//                read           read request
//                waitrequest    slave stall, master holds address/read
//                readdata       32-bit read data
//                readdatavalid  readdata valid strobe
//  Revision    : 1.0  initial release
// ============================================================================
interface sysid_boot_checker_if;
    logic        address;
    logic        read;
    logic        waitrequest;
    logic [31:0] readdata;
    logic        readdatavalid;

    modport master (
        output address,
        output read,
        input  waitrequest,
        input  readdata,
        input  readdatavalid
    );

    modport slave (
        input  address,
        input  read,
        output waitrequest,
        output readdata,
        output readdatavalid
    );
endinterface
`default_nettype wire

// File: rtl/sysid_read_timer.sv
`default_nettype none
// ============================================================================
//  Module      : sysid_read_timer
//  Description : Per-read watchdog counter. load clears the count, enable
//                advances it, expired is high while the count equals LIMIT.
//                The count saturates at LIMIT so a held enable never wraps.
//  Ports       : clock    system clock
//                reset_n  asynchronous active-low reset
//                load     clear count to zero (wins over enable)
//                enable   advance count by one
//                expired  count has reached LIMIT
//  Revision    : 1.0  initial release
// ============================================================================
module sysid_read_timer #(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] LIMIT = '1
) (
    input  wire logic clock,
    input  wire logic reset_n,
    input  wire logic load,
    input  wire logic enable,
    output logic      expired
);

    logic [WIDTH-1:0] r_count;

    assign expired = (r_count == LIMIT);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= '0;
        end else if (enable && !expired) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sysid_boot_checker.sv
`default_nettype none
// ============================================================================
//  Module      : sysid_boot_checker
//  Description : Avalon-MM master that reads the sysid ID word then the
//                timestamp word after reset (or on a start pulse) and reports
//                pass / mismatch / timeout to boot code and LED logic.
//  Ports       : clock      system clock
//                reset_n    asynchronous active-low reset
//                start      one-cycle pulse, re-run the check when idle
//                avm        Avalon-MM master port (sysid_boot_checker_if)
//                busy       sequence in progress
//                done       one-cycle pulse at the end of any sequence
//                pass       sticky: both words matched
//                mismatch   sticky: a word differed from its expected value
//                timeout    sticky: retries exhausted on a read timeout
//                id_value   last captured ID word
//                ts_value   last captured timestamp word
//  Revision    : 1.0  initial release
// ============================================================================
module sysid_boot_checker
    import sysid_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_TS    = 32'd1429704688,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd255,
    parameter int          MAX_RETRIES    = 2
) (
    input  wire logic                 clock,
    input  wire logic                 reset_n,
    input  wire logic                 start,
    sysid_boot_checker_if.master      avm,
    output logic                      busy,
    output logic                      done,
    output logic                      pass,
    output logic                      mismatch,
    output logic                      timeout,
    output logic [31:0]               id_value,
    output logic [31:0]               ts_value
);

    localparam logic [2:0] C_MAX_RETRIES = 3'(MAX_RETRIES);

    state_t      r_state;
    state_t      w_state_nx;
    logic [2:0]  r_retry;
    logic [2:0]  w_retry_nx;
    logic        r_auto_start;
    logic        w_auto_nx;
    logic        w_busy_nx;
    logic        w_done_nx;
    logic        w_pass_nx;
    logic        w_mismatch_nx;
    logic        w_timeout_nx;
    logic [31:0] w_id_nx;
    logic [31:0] w_ts_nx;
    logic        w_read_nx;
    logic        w_addr_nx;
    logic        w_abort;
    logic        w_load;
    logic        w_enable;
    logic        w_expired;

    // The watchdog runs only while a read is outstanding.
    assign w_enable = is_rd_state(r_state) || (r_state == S_WT_ID) || (r_state == S_WT_TS);

    sysid_read_timer #(
        .WIDTH (16),
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timer (
        .clock   (clock),
        .reset_n (reset_n),
        .load    (w_load),
        .enable  (w_enable),
        .expired (w_expired)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx    = r_state;
        w_retry_nx    = r_retry;
        w_auto_nx     = r_auto_start;
        w_busy_nx     = busy;
        w_done_nx     = 1'b0;
        w_pass_nx     = pass;
        w_mismatch_nx = mismatch;
        w_timeout_nx  = timeout;
        w_id_nx       = id_value;
        w_ts_nx       = ts_value;
        w_abort       = 1'b0;
        w_load        = 1'b0;

        case (r_state)
            S_IDLE: begin
                // A start arriving with the end-of-sequence pulse is treated
                // as arriving while busy and dropped.
                if (r_auto_start || (start && !done)) begin
                    w_auto_nx     = 1'b0;
                    w_pass_nx     = 1'b0;
                    w_mismatch_nx = 1'b0;
                    w_timeout_nx  = 1'b0;
                    w_busy_nx     = 1'b1;
                    w_retry_nx    = 3'd0;
                    w_state_nx    = S_RD_ID;
                    w_load        = 1'b1;
                end
            end
            S_RD_ID: begin
                if (!avm.waitrequest) begin
                    // Zero-latency slave: data arrives with the accept.
                    if (avm.readdatavalid) begin
                        w_id_nx    = avm.readdata;
                        w_state_nx = S_RD_TS;
                        w_load     = 1'b1;
                    end else begin
                        w_state_nx = S_WT_ID;
                    end
                end else if (w_expired) begin
                    w_abort = 1'b1;
                end
            end
            S_WT_ID: begin
                if (avm.readdatavalid) begin
                    w_id_nx    = avm.readdata;
                    w_state_nx = S_RD_TS;
                    w_load     = 1'b1;
                end else if (w_expired) begin
                    w_abort = 1'b1;
                end
            end
            S_RD_TS: begin
                if (!avm.waitrequest) begin
                    if (avm.readdatavalid) begin
                        w_ts_nx    = avm.readdata;
                        w_state_nx = S_CHECK;
                    end else begin
                        w_state_nx = S_WT_TS;
                    end
                end else if (w_expired) begin
                    w_abort = 1'b1;
                end
            end
            S_WT_TS: begin
                if (avm.readdatavalid) begin
                    w_ts_nx    = avm.readdata;
                    w_state_nx = S_CHECK;
                end else if (w_expired) begin
                    w_abort = 1'b1;
                end
            end
            S_CHECK: begin
                w_pass_nx     = (id_value == EXPECTED_ID) && (ts_value == EXPECTED_TS);
                w_mismatch_nx = !((id_value == EXPECTED_ID) && (ts_value == EXPECTED_TS));
                w_done_nx     = 1'b1;
                w_busy_nx     = 1'b0;
                w_state_nx    = S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase

        // A timed-out read restarts the whole sequence from the ID word.
        if (w_abort) begin
            if (r_retry < C_MAX_RETRIES) begin
                w_retry_nx = r_retry + 3'd1;
                w_state_nx = S_RD_ID;
                w_load     = 1'b1;
            end else begin
                w_timeout_nx = 1'b1;
                w_done_nx    = 1'b1;
                w_busy_nx    = 1'b0;
                w_state_nx   = S_IDLE;
            end
        end
    end

    // Bus outputs are registered from the next state, so read is high
    // exactly while the FSM sits in a read-request state.
    always_comb begin
        w_read_nx = is_rd_state(w_state_nx);
        if (w_state_nx == S_RD_TS) begin
            w_addr_nx = ADDR_TS;
        end else if (w_state_nx == S_RD_ID) begin
            w_addr_nx = ADDR_ID;
        end else begin
            w_addr_nx = avm.address;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_retry      <= 3'd0;
            r_auto_start <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            mismatch     <= 1'b0;
            timeout      <= 1'b0;
            id_value     <= 32'h0;
            ts_value     <= 32'h0;
            avm.read     <= 1'b0;
            avm.address  <= ADDR_ID;
        end else begin
            r_retry      <= w_retry_nx;
            r_auto_start <= w_auto_nx;
            busy         <= w_busy_nx;
            done         <= w_done_nx;
            pass         <= w_pass_nx;
            mismatch     <= w_mismatch_nx;
            timeout      <= w_timeout_nx;
            id_value     <= w_id_nx;
            ts_value     <= w_ts_nx;
            avm.read     <= w_read_nx;
            avm.address  <= w_addr_nx;
        end
    end

endmodule
`default_nettype wire
